// File: rtl/sample_capture_pkg.sv
// Shared types and defaults for the frame sample buffer.
// State enum covers the optional trigger-armed state as well.
package sample_capture_pkg;

   typedef enum logic [1:0] {
      CAPTURE,
      DRAIN,
      FLUSH,
      ARMED
   } state_t;

   localparam int DATA_W_DEF    = 8;
   localparam int FRAME_LEN_DEF = 64;

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port frame RAM: synchronous write, registered read.
// Only the read register is reset; the array contents are not.
module sample_capture_ram
   import sample_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register holds between reads so the replayed sample stays stable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sample_capture.sv
// Frame capture buffer: fill FRAME_LEN samples, replay under read_ready.
// SAMPLE_CAPTURE_TRIG_EN adds a rising-crossing trigger before capture.
module sample_capture
   import sample_capture_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
`ifdef SAMPLE_CAPTURE_TRIG_EN
   parameter int TRIG_LEVEL = 128,
`endif
   localparam int ADDR_W   = $clog2(FRAME_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              new_sample_in,
   input  logic              read_ready,
   output logic              frame_full,
   output logic [DATA_W-1:0] sample_out,
   output logic              new_sample_out,
   output logic              frame_end
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

`ifdef SAMPLE_CAPTURE_TRIG_EN
   localparam state_t START = ARMED;
   localparam logic [DATA_W-1:0] TRIG = DATA_W'(TRIG_LEVEL);
   logic prev_low;
`else
   localparam state_t START = CAPTURE;
`endif

   state_t state, next;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic wr_en, rd_en;

   always_comb begin
      next  = state;
      wr_en = 1'b0;
      rd_en = 1'b0;
      case (state)
         CAPTURE: begin
            if (new_sample_in) begin
               wr_en = 1'b1;
               if (wr_ptr == LAST) next = DRAIN;
            end
         end
         DRAIN: begin
            if (read_ready) begin
               rd_en = 1'b1;
               if (rd_ptr == LAST) next = FLUSH;
            end
         end
         FLUSH: next = START;
`ifdef SAMPLE_CAPTURE_TRIG_EN
         ARMED: begin
            // Triggering sample becomes index 0 of the frame.
            if (new_sample_in && prev_low && sample_in >= TRIG) begin
               wr_en = 1'b1;
               next  = CAPTURE;
            end
         end
`endif
         default: next = START;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= START;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         frame_full     <= 1'b0;
         new_sample_out <= 1'b0;
         frame_end      <= 1'b0;
      end else begin
         state          <= next;
         frame_full     <= (next == DRAIN);
         new_sample_out <= rd_en;
         frame_end      <= rd_en && (rd_ptr == LAST);
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

`ifdef SAMPLE_CAPTURE_TRIG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                 prev_low <= 1'b0;
      else if (state != ARMED)                  prev_low <= 1'b0;
      else if (new_sample_in)                   prev_low <= (sample_in < TRIG);
   end
`endif

   sample_capture_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .wr_addr(wr_ptr),
      .wr_data(sample_in),
      .rd_en  (rd_en),
      .rd_addr(rd_ptr),
      .rd_data(sample_out)
   );

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with FRAME_LEN=8.
// Built with SAMPLE_CAPTURE_TRIG_EN it runs the trigger ramp instead.
module tb_sample_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sample_in;
   logic       new_sample_in;
   logic       read_ready;
   logic       frame_full;
   logic [7:0] sample_out;
   logic       new_sample_out;
   logic       frame_end;

   int checks = 0;
   int errors = 0;

   sample_capture #(
      .DATA_W   (8),
      .FRAME_LEN(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_in     (sample_in),
      .new_sample_in (new_sample_in),
      .read_ready    (read_ready),
      .frame_full    (frame_full),
      .sample_out    (sample_out),
      .new_sample_out(new_sample_out),
      .frame_end     (frame_end)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_full"}, int'(frame_full), 0);
      check({tag, "_nso"}, int'(new_sample_out), 0);
      check({tag, "_fe"}, int'(frame_end), 0);
      check({tag, "_out"}, int'(sample_out), 0);
   endtask

   // Writes base..base+7, with gap idle cycles between writes.
   task automatic fill(input int base, input int gap);
      for (int i = 0; i < 8; i++) begin
         sample_in     = 8'(base + i);
         new_sample_in = 1'b1;
         tick();
         new_sample_in = 1'b0;
         check("fill_full", int'(frame_full), (i == 7) ? 1 : 0);
         if (i < 7) begin
            for (int g = 0; g < gap; g++) begin
               tick();
               check("gap_full", int'(frame_full), 0);
            end
         end
      end
   endtask

   // Starts on the first DRAIN cycle; expects base..base+7 back.
   task automatic drain(input int base, input bit toggle);
      int n, first, last;
      n = 0;
      first = -1;
      last = 0;
      for (int c = 0; c < 64 && n < 8; c++) begin
         if (toggle) read_ready = (c % 2 == 0);
         tick();
         if (new_sample_out) begin
            if (first < 0) first = c;
            last = c;
            check("drain_data", int'(sample_out), base + n);
            check("drain_fe", int'(frame_end), (n == 7) ? 1 : 0);
            check("drain_full", int'(frame_full), (n == 7) ? 0 : 1);
            n++;
         end else begin
            check("fe_alone", int'(frame_end), 0);
         end
      end
      read_ready = 1'b1;
      check("drain_count", n, 8);
      check("drain_first", first, 0);
      check("drain_span", last - first, toggle ? 14 : 7);
      tick();
      check("post_nso", int'(new_sample_out), 0);
      check("post_full", int'(frame_full), 0);
   endtask

   initial begin
      int n, seen;
      rst           = 1'b0;
      sample_in     = '0;
      new_sample_in = 1'b0;
      read_ready    = 1'b1;
      repeat (3) tick();
      check_idle("reset");
      rst = 1'b1;
      tick();
      check_idle("armed");

`ifdef SAMPLE_CAPTURE_TRIG_EN
      seen = 0;
      for (int v = 120; v <= 140; v++) begin
         sample_in     = 8'(v);
         new_sample_in = 1'b1;
         tick();
         if (frame_full) begin
            seen = v;
            break;
         end
      end
      new_sample_in = 1'b0;
      check("trig_last_write", seen, 135);
      drain(128, 1'b0);
`else
      // Basic frame with read_ready held high.
      fill(0, 0);
      drain(0, 1'b0);

      // Three frames under continuous input; dropped values must not appear.
      n = 0;
      for (int c = 0; c <= 50; c++) begin
         if (new_sample_out) begin
            check("cont_data", int'(sample_out), 17 * (n / 8) + (n % 8));
            check("cont_fe", int'(frame_end), (n % 8 == 7) ? 1 : 0);
            n++;
         end
         sample_in     = 8'(c);
         new_sample_in = 1'b1;
         tick();
      end
      new_sample_in = 1'b0;
      check("cont_count", n, 24);
      check("cont_idle", int'(new_sample_out), 0);

      // Paced read side.
      read_ready = 1'b0;
      fill(20, 0);
      drain(20, 1'b1);

      // Sparse writes, one every third cycle.
      fill(40, 2);
      drain(40, 1'b0);

      // Reset in the middle of a drain.
      fill(60, 0);
      seen = 0;
      for (int c = 0; c < 20 && seen < 3; c++) begin
         tick();
         if (new_sample_out) seen++;
      end
      check("mid_seen", seen, 3);
      check("mid_last", int'(sample_out), 62);
      rst = 1'b0;
      #1;
      check_idle("async_rst");
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_idle("after_rst");
      fill(100, 0);
      drain(100, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Frame-based sample buffer sitting between a sample source (e.g. ADC front-end) and a downstream consumer (e.g. serial/USB streamer).
- Captures FRAME_LEN consecutive samples into an internal RAM and raises frame_full.
- Replays the frame in order under read_ready flow control, marking the last sample with frame_end, then re-arms for the next frame.

Parameters:
- DATA_W, 8, sample width in bits.
- FRAME_LEN, 64, samples per frame; must be a power of two, ≥ 2.
- ADDR_W, $clog2(FRAME_LEN), RAM address width; derived, never overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clock clk.
- sample_in  in  DATA_W  incoming sample.
- new_sample_in  in  1  sample_in valid this cycle.
- read_ready  in  1  consumer can accept a sample; may be held high continuously.
- frame_full  out  1  buffer holds an unread or draining frame; new samples are dropped.
- sample_out  out  DATA_W  replayed sample.
- new_sample_out  out  1  one-cycle strobe: sample_out valid.
- frame_end  out  1  high together with new_sample_out on the last sample of a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = CAPTURE; wr_ptr = 0; rd_ptr = 0.
  - frame_full = 0, new_sample_out = 0, frame_end = 0, sample_out = 0.
  - RAM contents are not reset.
- FSM states: CAPTURE, DRAIN, FLUSH.
- CAPTURE:
  - Each cycle with new_sample_in=1: mem[wr_ptr] <= sample_in; wr_ptr increments.
  - When the write is to index FRAME_LEN-1: wr_ptr wraps to 0, state → DRAIN, frame_full=1 from the next cycle.
  - read_ready is ignored.
- DRAIN:
  - new_sample_in is ignored; samples are dropped, with no error flag.
  - Each cycle with read_ready=1: issue a synchronous RAM read of mem[rd_ptr]; rd_ptr increments.
  - One cycle after each read is issued: sample_out = the data read and new_sample_out = 1.
  - The read of index FRAME_LEN-1 wraps rd_ptr to 0 and sends state → FLUSH.
  - read_ready=0 pauses reads; a read already issued still appears on the next cycle.
- FLUSH (single cycle):
  - Last sample presented with new_sample_out=1 and frame_end=1.
  - frame_full falls to 0 on this same edge; state → CAPTURE.
  - new_sample_in in the FLUSH cycle is dropped. The first accepted sample of the next frame is the first cycle after frame_end.
- Outputs are registered:
  - sample_out holds its last value when new_sample_out=0.
  - frame_end is never high without new_sample_out.
- Timing:
  - Throughput: one sample per cycle in both directions.
  - Latency from last write to first new_sample_out, with read_ready held high: 2 cycles.
  - Samples leave in write order.
- Reset mid-operation aborts the frame: pointers clear, and partial or unread data is discarded.

Optional Feature:
- Macro: SAMPLE_CAPTURE_TRIG_EN.
- Defined:
  - Adds parameter TRIG_LEVEL (default 128) and state ARMED, entered from reset and from FLUSH instead of CAPTURE.
  - In ARMED, valid samples are discarded until a valid sample ≥ TRIG_LEVEL immediately follows a valid sample < TRIG_LEVEL (rising crossing).
  - That triggering sample is written as index 0 and the state moves to CAPTURE.
- Undefined: no ARMED state; capture starts immediately after reset or FLUSH, exactly as described above.

Decomposition:
- Package sample_capture_pkg holds:
  - the FSM state enum (CAPTURE, DRAIN, FLUSH, ARMED);
  - default constants DATA_W_DEF=8 and FRAME_LEN_DEF=64.
- One sub-module, sample_capture_ram: simple dual-port RAM with FRAME_LEN×DATA_W, a synchronous write port and a registered synchronous read port.
- FSM and pointers live in the top level.

Test Plan:
- FRAME_LEN=8, read_ready=1, samples 0..7 on consecutive cycles:
  - frame_full rises the cycle after sample 7;
  - sample_out emits 0..7 with new_sample_out on 8 consecutive cycles;
  - frame_end only on 7;
  - frame_full falls with frame_end.
- Continuous new_sample_in with incrementing data across 3 frames: each frame emits 8 contiguous values, and values offered while frame_full=1 never appear.
- read_ready toggled 1/0 each cycle during DRAIN: samples 0..7 still emitted in order, one per two cycles, and frame_end coincides with 7.
- Gapped new_sample_in (every third cycle): exactly 8 writes fill the frame, and frame_full rises only after the 8th.
- rst asserted mid-DRAIN after 3 samples are output: all outputs go 0 immediately; the next frame starts writing at index 0 and replays from its own first sample.
- With SAMPLE_CAPTURE_TRIG_EN, TRIG_LEVEL=128, input ramp 120..140: the first stored sample is 128, and the frame replays 128..135.
